// File: rtl/tick_scheduler_if.sv
// Bus between the frame timing logic, the configuration source and the event consumer
// of tick_scheduler. The master drives ticks, configuration and ev_ready.
interface tick_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int IW      = 8
);
   logic               frame_tick;
   logic               pause;
   logic               cfg_valid;
   logic [1:0]         cfg_id;
   logic [IW-1:0]      cfg_interval;
   logic               ev_valid;
   logic [1:0]         ev_id;
   logic               ev_ready;
   logic [NUM_REQ-1:0] overrun;
   logic               overrun_clr;

   modport master (
      output frame_tick, pause, cfg_valid, cfg_id, cfg_interval, ev_ready, overrun_clr,
      input  ev_valid, ev_id, overrun
   );

   modport slave (
      input  frame_tick, pause, cfg_valid, cfg_id, cfg_interval, ev_ready, overrun_clr,
      output ev_valid, ev_id, overrun
   );
endinterface

// File: rtl/tick_scheduler.sv
// Per-requester frame interval counters; due events are shared on one valid/ready port
// through a round-robin arbiter, with sticky overrun flags for events that get lost.
module tick_scheduler #(
   parameter int IW = 8
) (
   input  logic             clk,
   input  logic             reset,
   tick_scheduler_if.slave  bus
);
   localparam int            NUM_REQ = 4;
   localparam logic [IW-1:0] CNT_ZERO = {IW{1'b0}};
   localparam logic [IW-1:0] CNT_ONE  = {{(IW-1){1'b0}}, 1'b1};

   logic [IW-1:0]      interval_q [NUM_REQ];
   logic [IW-1:0]      interval_d [NUM_REQ];
   logic [IW-1:0]      counter_q  [NUM_REQ];
   logic [IW-1:0]      counter_d  [NUM_REQ];
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [NUM_REQ-1:0] overrun_q, overrun_d;
   logic               ev_valid_q, ev_valid_d;
   logic [1:0]         ev_id_q, ev_id_d;
   logic [1:0]         rr_ptr_q, rr_ptr_d;

   logic               tick_s;
   logic               load_s;
   logic               gnt_any_s;
   logic [1:0]         gnt_id_s;
   logic               hit_s;
   logic [NUM_REQ-1:0] gnt_oh_s;
   logic [NUM_REQ-1:0] cfg_hit_s;
   logic [NUM_REQ-1:0] expire_s;

   assign tick_s = bus.frame_tick & ~bus.pause;
   assign load_s = ~ev_valid_q | bus.ev_ready;

   // Round-robin pick: first pending id at or after rr_ptr, only when the stage can load
   always_comb begin
      gnt_any_s = 1'b0;
      gnt_id_s  = 2'd0;
      hit_s     = 1'b0;
      gnt_oh_s  = {NUM_REQ{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         hit_s     = load_s & ~gnt_any_s & pending_q[rr_ptr_q + 2'(k)];
         gnt_id_s  = hit_s ? (rr_ptr_q + 2'(k)) : gnt_id_s;
         gnt_any_s = gnt_any_s | hit_s;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt_oh_s[i] = gnt_any_s & (gnt_id_s == 2'(i));
      end
   end

   // Per-requester next state: configuration beats a tick for its own id only
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         cfg_hit_s[i] = bus.cfg_valid & (bus.cfg_id == 2'(i));
         expire_s[i]  = tick_s & ~cfg_hit_s[i] & (interval_q[i] != CNT_ZERO)
                        & (counter_q[i] == CNT_ONE);
         interval_d[i] = interval_q[i];
         counter_d[i]  = counter_q[i];
         pending_d[i]  = pending_q[i];
         if (cfg_hit_s[i]) begin
            interval_d[i] = bus.cfg_interval;
            counter_d[i]  = bus.cfg_interval;
            pending_d[i]  = 1'b0;
         end else if (tick_s && (interval_q[i] != CNT_ZERO)) begin
            counter_d[i] = expire_s[i] ? interval_q[i] : (counter_q[i] - CNT_ONE);
            pending_d[i] = expire_s[i] | (pending_q[i] & ~gnt_oh_s[i]);
         end else begin
            pending_d[i] = pending_q[i] & ~gnt_oh_s[i];
         end
         // A same-cycle overrun wins over the clear
         overrun_d[i] = (expire_s[i] & pending_q[i] & ~gnt_oh_s[i])
                        | (overrun_q[i] & ~bus.overrun_clr);
      end
   end

   // Output stage: reload on empty or handshake, otherwise hold valid and id
   always_comb begin
      ev_valid_d = ev_valid_q;
      ev_id_d    = ev_id_q;
      rr_ptr_d   = rr_ptr_q;
      if (load_s) begin
         ev_valid_d = gnt_any_s;
         if (gnt_any_s) begin
            ev_id_d  = gnt_id_s;
            rr_ptr_d = gnt_id_s + 2'd1;
         end else begin
            ev_id_d  = ev_id_q;
         end
      end else begin
         ev_valid_d = ev_valid_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            interval_q[i] <= CNT_ZERO;
            counter_q[i]  <= CNT_ZERO;
         end
         pending_q  <= {NUM_REQ{1'b0}};
         overrun_q  <= {NUM_REQ{1'b0}};
         ev_valid_q <= 1'b0;
         ev_id_q    <= 2'd0;
         rr_ptr_q   <= 2'd0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            interval_q[i] <= interval_d[i];
            counter_q[i]  <= counter_d[i];
         end
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
         ev_valid_q <= ev_valid_d;
         ev_id_q    <= ev_id_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign bus.ev_valid = ev_valid_q;
   assign bus.ev_id    = ev_id_q;
   assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed scenarios plus randomized traffic for tick_scheduler, checked every cycle
// against a frames-remaining reference model.
module tb_tick_scheduler;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   hs_q[$];

   // reference model state
   int   m_period [4];
   int   m_left   [4];
   bit   m_due    [4];
   bit   m_lost   [4];
   bit   m_vld;
   int   m_id;
   int   m_next;

   tick_scheduler_if bus ();

   tick_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [3:0] lost_vec();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = m_lost[i];
      return v;
   endfunction

   task automatic model_update();
      bit tick, can_load, cfgh, fire;
      int winner;
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            m_period[i] = 0; m_left[i] = 0; m_due[i] = 0; m_lost[i] = 0;
         end
         m_vld = 0; m_id = 0; m_next = 0;
         return;
      end
      tick     = bus.frame_tick && !bus.pause;
      can_load = !m_vld || bus.ev_ready;
      winner   = -1;
      if (can_load)
         for (int k = 0; k < 4; k++)
            if (winner < 0 && m_due[(m_next + k) % 4]) winner = (m_next + k) % 4;
      for (int i = 0; i < 4; i++) begin
         cfgh = bus.cfg_valid && (int'(bus.cfg_id) == i);
         fire = tick && !cfgh && m_period[i] != 0 && m_left[i] == 1;
         if (fire && m_due[i] && winner != i) m_lost[i] = 1;
         else if (bus.overrun_clr) m_lost[i] = 0;
         if (cfgh) begin
            m_period[i] = int'(bus.cfg_interval);
            m_left[i]   = int'(bus.cfg_interval);
            m_due[i]    = 0;
         end else begin
            if (tick && m_period[i] != 0) m_left[i] = fire ? m_period[i] : m_left[i] - 1;
            if (fire) m_due[i] = 1;
            else if (winner == i) m_due[i] = 0;
         end
      end
      if (can_load) begin
         if (winner >= 0) begin
            m_vld = 1; m_id = winner; m_next = (winner + 1) % 4;
         end else begin
            m_vld = 0;
         end
      end
   endtask

   task automatic step();
      if (bus.ev_valid === 1'b1 && bus.ev_ready === 1'b1 && !reset) hs_q.push_back(int'(bus.ev_id));
      @(posedge clk);
      model_update();
      #1;
      cyc++;
      check("model_ev_valid", bus.ev_valid, m_vld);
      if (m_vld) check("model_ev_id", bus.ev_id, m_id);
      check("model_overrun", bus.overrun, lost_vec());
   endtask

   task automatic set_idle();
      reset = 1'b0;
      bus.frame_tick = 1'b0; bus.pause = 1'b0; bus.cfg_valid = 1'b0;
      bus.cfg_id = 2'd0; bus.cfg_interval = 8'd0; bus.overrun_clr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; step(); reset = 1'b0;
   endtask

   task automatic cfg(input int id, input int val);
      bus.cfg_valid = 1'b1; bus.cfg_id = 2'(id); bus.cfg_interval = 8'(val);
      step();
      bus.cfg_valid = 1'b0;
   endtask

   task automatic tick();
      bus.frame_tick = 1'b1; step(); bus.frame_tick = 1'b0;
   endtask

   initial begin
      int n3;
      set_idle();
      bus.ev_ready = 1'b0;
      do_reset();

      // reset in the middle of a stalled handshake
      cfg(0, 1);
      tick(); step();
      check("rst_pre_valid", bus.ev_valid, 1);
      reset = 1'b1; step(); reset = 1'b0;
      check("rst_valid", bus.ev_valid, 0);
      check("rst_overrun", bus.overrun, 0);
      bus.ev_ready = 1'b1;
      hs_q.delete();
      repeat (10) begin tick(); step(); end
      check("rst_no_events", hs_q.size(), 0);

      // single period of 3 frames
      do_reset();
      cfg(1, 3);
      hs_q.delete();
      for (int t = 1; t <= 9; t++) begin
         tick();
         check("sp_t1_valid", bus.ev_valid, 0);
         step();
         check("sp_t2_valid", bus.ev_valid, (t % 3 == 0) ? 1 : 0);
         if (t % 3 == 0) check("sp_t2_id", bus.ev_id, 1);
         step();
         check("sp_t3_valid", bus.ev_valid, 0);
      end
      check("sp_count", hs_q.size(), 3);
      foreach (hs_q[j]) check("sp_hs_id", hs_q[j], 1);

      // round-robin ordering over two rounds
      do_reset();
      for (int i = 0; i < 4; i++) cfg(i, 1);
      bus.ev_ready = 1'b0;
      tick(); step();
      for (int r = 0; r < 2; r++) begin
         bus.ev_ready = 1'b1;
         for (int k = 0; k < 4; k++) begin
            check("rr_valid", bus.ev_valid, 1);
            check("rr_order", bus.ev_id, k);
            step();
         end
         check("rr_drained", bus.ev_valid, 0);
         if (r == 0) begin tick(); step(); end
      end

      // backpressure with overrun, then clear
      do_reset();
      bus.ev_ready = 1'b0;
      cfg(2, 1);
      for (int t = 1; t <= 3; t++) begin
         tick(); step();
         check("bp_valid", bus.ev_valid, 1);
         check("bp_id_stable", bus.ev_id, 2);
         check("bp_overrun", bus.overrun, (t == 3) ? 4 : 0);
      end
      bus.overrun_clr = 1'b1; step(); bus.overrun_clr = 1'b0;
      check("bp_overrun_clr", bus.overrun, 0);
      bus.ev_ready = 1'b1;
      repeat (4) step();

      // pause freezes counting
      do_reset();
      cfg(0, 4);
      tick(); step(); tick(); step();
      bus.pause = 1'b1;
      repeat (5) begin tick(); step(); check("pause_hold", bus.ev_valid, 0); end
      bus.pause = 1'b0;
      tick(); step();
      check("pause_rel1", bus.ev_valid, 0);
      tick(); step();
      check("pause_rel2_valid", bus.ev_valid, 1);
      check("pause_rel2_id", bus.ev_id, 0);
      step();

      // disabling id3 in the cycle it would expire
      do_reset();
      for (int i = 0; i < 4; i++) cfg(i, 2);
      tick(); step(); step();
      hs_q.delete();
      bus.frame_tick = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_id = 2'd3; bus.cfg_interval = 8'd0;
      step();
      bus.frame_tick = 1'b0; bus.cfg_valid = 1'b0;
      repeat (6) step();
      check("sc_count", hs_q.size(), 3);
      for (int j = 0; j < 3 && j < hs_q.size(); j++) check("sc_order", hs_q[j], j);
      repeat (2) begin tick(); repeat (5) step(); end
      n3 = 0;
      foreach (hs_q[j]) if (hs_q[j] == 3) n3++;
      check("sc_total", hs_q.size(), 6);
      check("sc_no_id3", n3, 0);

      // randomized traffic against the model
      do_reset();
      repeat (4000) begin
         reset           = ($urandom_range(0, 499) == 0);
         bus.frame_tick  = ($urandom_range(0, 2) == 0);
         bus.pause       = ($urandom_range(0, 7) == 0);
         bus.ev_ready    = $urandom_range(0, 1);
         bus.overrun_clr = ($urandom_range(0, 31) == 0);
         bus.cfg_valid   = ($urandom_range(0, 15) == 0);
         bus.cfg_id      = 2'($urandom_range(0, 3));
         bus.cfg_interval = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                         : 8'($urandom_range(0, 6));
         step();
      end
      set_idle();
      bus.ev_ready = 1'b1;
      repeat (20) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
